// File: rtl/id_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_pkg                                                          |
// | Purpose  : Shared constants and types for the id_stage_pipelined decode   |
// |            stage: EX commands, opcode/mode/condition encodings, NZCV bit  |
// |            positions, the ID/EX control bundle and the condition check.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package id_pkg;

  // EX-stage ALU commands
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Instruction classes, instr[27:26]
  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // NZCV bit positions inside the status word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control bundle carried through the ID/EX register
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       b;
    logic       s;
  } id_ctrl_t;

  // True when the condition field allows execution under the given flags.
  // 1111 falls through to the default and never executes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_pipelined_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_stage_pipelined_if                                           |
// | Purpose  : Bundle of the decode stage's upstream handshake (in_*), the    |
// |            ID/EX register outputs (out_*) and the unregistered hazard     |
// |            source info (hz_*).                                             |
// |            modport slave  : the decode stage itself                        |
// |            modport master : the surrounding pipeline (IF/ID, EX, hazard)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface id_stage_pipelined_if #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int IMM_W   = 24,
  parameter int SHOP_W  = 12
);
  localparam int RA_W = $clog2(REG_CNT);

  // upstream handshake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [31:0]       in_instr;

  // hazard-unit side, combinational from in_instr
  logic [RA_W-1:0]   hz_src1;
  logic [RA_W-1:0]   hz_src2;
  logic              hz_two_src;

  // ID/EX register
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_rn;
  logic [DATA_W-1:0] out_rm;
  logic [RA_W-1:0]   out_dst;
  logic [RA_W-1:0]   out_src1;
  logic [RA_W-1:0]   out_src2;
  logic [IMM_W-1:0]  out_imm24;
  logic [SHOP_W-1:0] out_shop;
  logic              out_imm;
  logic [3:0]        out_exe_cmd;
  logic              out_mem_r;
  logic              out_mem_w;
  logic              out_wb;
  logic              out_b;
  logic              out_s;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, hz_src1, hz_src2, hz_two_src,
    output out_valid, out_pc, out_rn, out_rm, out_dst, out_src1, out_src2,
    output out_imm24, out_shop, out_imm, out_exe_cmd,
    output out_mem_r, out_mem_w, out_wb, out_b, out_s
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, hz_src1, hz_src2, hz_two_src,
    input  out_valid, out_pc, out_rn, out_rm, out_dst, out_src1, out_src2,
    input  out_imm24, out_shop, out_imm, out_exe_cmd,
    input  out_mem_r, out_mem_w, out_wb, out_b, out_s
  );
endinterface
`default_nettype wire

// File: rtl/id_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_regfile                                                      |
// | Purpose  : REG_CNT x DATA_W register file, one posedge write port, two    |
// |            asynchronous read ports, asynchronous reset to zero.            |
// |            Optional macro DECODE_WB_BYPASS_EN: a read whose address       |
// |            matches an enabled write in the same cycle returns wr_data.     |
// |            Without it reads return the pre-write value.                   |
// | Ports    : clk, rst                 clock / async active-high reset        |
// |            wr_en, wr_addr, wr_data  write port (out-of-range ignored)      |
// |            rd1_addr/rd1_data        read port 1                            |
// |            rd2_addr/rd2_data        read port 2                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module id_regfile #(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 16,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RA_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [RA_W-1:0]   rd2_addr,
  output logic [DATA_W-1:0] rd2_data
);

  localparam logic [RA_W:0] c_reg_cnt = (RA_W+1)'(REG_CNT);

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] mem_d [REG_CNT];
  logic              wr_ok;

  // Address space may be wider than the register count when REG_CNT is
  // not a power of two; those writes are dropped.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < c_reg_cnt);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd1_data = '0;
    if ({1'b0, rd1_addr} < c_reg_cnt) begin
      rd1_data = mem_q[rd1_addr];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok && (wr_addr == rd1_addr)) begin
      rd1_data = wr_data;
    end
`endif
  end

  always_comb begin
    rd2_data = '0;
    if ({1'b0, rd2_addr} < c_reg_cnt) begin
      rd2_data = mem_q[rd2_addr];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok && (wr_addr == rd2_addr)) begin
      rd2_data = wr_data;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_stage_pipelined                                              |
// | Purpose  : Decode stage merging instruction decode, condition check,      |
// |            register file and the ID/EX pipeline register, with a          |
// |            valid/ready handshake, flush and hazard bubbles.                |
// |            Optional macro DECODE_WB_BYPASS_EN enables register-file        |
// |            write-through (see id_regfile).                                 |
// | Ports    : clk, rst        clock / async active-high reset                 |
// |            status          NZCV flags used for the condition check         |
// |            hazard          hazard unit requests a bubble                   |
// |            flush           taken branch, kills the held instruction        |
// |            wb_en/addr/data register-file write port                        |
// |            bus (slave)     in_* handshake, out_* ID/EX register, hz_*      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 16,
  parameter  int IMM_W   = 24,
  parameter  int SHOP_W  = 12,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           status,
  input  logic                 hazard,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [RA_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  id_stage_pipelined_if.slave  bus
);

  // ---------------------------------------------------------------- fields
  logic [3:0]        cond_f;
  logic [1:0]        mode_f;
  logic [3:0]        op_f;
  logic              s_bit;
  logic              imm_bit;
  logic              is_store;
  logic              has_src1;
  logic              alu_def;
  logic              cond_ok;
  logic [RA_W-1:0]   src1;
  logic [RA_W-1:0]   src2;
  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  id_ctrl_t          ctrl_raw;
  id_ctrl_t          ctrl;
  logic              in_ready;
  logic              accept;

  assign cond_f  = bus.in_instr[31:28];
  assign mode_f  = bus.in_instr[27:26];
  assign imm_bit = bus.in_instr[25];
  assign op_f    = bus.in_instr[24:21];
  assign s_bit   = bus.in_instr[20];

  // Store reads its data register from the Rd field instead of Rm.
  assign is_store = (mode_f == MODE_MEM) && !s_bit;
  assign has_src1 = !(((mode_f == MODE_ALU) && ((op_f == OP_MOV) || (op_f == OP_MVN)))
                      || (mode_f == MODE_BR));

  assign src1 = bus.in_instr[16 +: RA_W];
  assign src2 = is_store ? bus.in_instr[12 +: RA_W] : bus.in_instr[0 +: RA_W];

  assign bus.hz_src1    = src1;
  assign bus.hz_src2    = src2;
  assign bus.hz_two_src = (!imm_bit || is_store) || has_src1;

  // ---------------------------------------------------------------- decode
  always_comb begin
    ctrl_raw = '0;
    alu_def  = 1'b1;
    case (mode_f)
      MODE_ALU: begin
        case (op_f)
          OP_MOV:  ctrl_raw.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl_raw.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl_raw.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl_raw.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl_raw.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl_raw.exe_cmd = EXE_SBC;
          OP_AND:  ctrl_raw.exe_cmd = EXE_AND;
          OP_ORR:  ctrl_raw.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl_raw.exe_cmd = EXE_EOR;
          OP_CMP:  ctrl_raw.exe_cmd = EXE_SUB;
          OP_TST:  ctrl_raw.exe_cmd = EXE_AND;
          default: alu_def = 1'b0;
        endcase
        if (alu_def) begin
          // compare/test only update flags
          ctrl_raw.wb = (op_f != OP_CMP) && (op_f != OP_TST);
          ctrl_raw.s  = s_bit;
        end
      end
      MODE_MEM: begin
        // address generation is an add; S distinguishes load from store
        ctrl_raw.exe_cmd = EXE_ADD;
        if (s_bit) begin
          ctrl_raw.mem_r = 1'b1;
          ctrl_raw.wb    = 1'b1;
        end else begin
          ctrl_raw.mem_w = 1'b1;
        end
      end
      MODE_BR: begin
        ctrl_raw.b = 1'b1;
      end
      default: ctrl_raw = '0;
    endcase
  end

  // A failed condition still occupies the slot but as a NOP.
  always_comb begin
    cond_ok = cond_pass(cond_f, status);
    ctrl    = cond_ok ? ctrl_raw : '0;
  end

  // --------------------------------------------------------- register file
  id_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd1_addr (src1),
    .rd1_data (rn_val),
    .rd2_addr (src2),
    .rd2_data (rm_val)
  );

  // ------------------------------------------------------- ID/EX register
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] rn_q,    rn_d;
  logic [DATA_W-1:0] rm_q,    rm_d;
  logic [RA_W-1:0]   dst_q,   dst_d;
  logic [RA_W-1:0]   src1_q,  src1_d;
  logic [RA_W-1:0]   src2_q,  src2_d;
  logic [IMM_W-1:0]  imm24_q, imm24_d;
  logic [SHOP_W-1:0] shop_q,  shop_d;
  logic              imm_q,   imm_d;
  id_ctrl_t          ctrl_q,  ctrl_d;

  assign in_ready     = !hazard && (!valid_q || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    dst_d   = dst_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    imm24_d = imm24_q;
    shop_d  = shop_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      // wins over hold: the held instruction is on the wrong path
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = bus.in_pc;
      rn_d    = rn_val;
      rm_d    = rm_val;
      dst_d   = bus.in_instr[12 +: RA_W];
      src1_d  = src1;
      src2_d  = src2;
      imm24_d = bus.in_instr[IMM_W-1:0];
      shop_d  = bus.in_instr[SHOP_W-1:0];
      imm_d   = imm_bit;
      ctrl_d  = ctrl;
    end else if (valid_q && !bus.out_ready) begin
      valid_d = 1'b1;
    end else begin
      // downstream took (or never had) the entry and nothing new came in
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      dst_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      imm24_q <= '0;
      shop_q  <= '0;
      imm_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      dst_q   <= dst_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      imm24_q <= imm24_d;
      shop_q  <= shop_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rn      = rn_q;
  assign bus.out_rm      = rm_q;
  assign bus.out_dst     = dst_q;
  assign bus.out_src1    = src1_q;
  assign bus.out_src2    = src2_q;
  assign bus.out_imm24   = imm24_q;
  assign bus.out_shop    = shop_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_exe_cmd = ctrl_q.exe_cmd;
  assign bus.out_mem_r   = ctrl_q.mem_r;
  assign bus.out_mem_w   = ctrl_q.mem_w;
  assign bus.out_wb      = ctrl_q.wb;
  assign bus.out_b       = ctrl_q.b;
  assign bus.out_s       = ctrl_q.s;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_id_stage_pipelined                                           |
// | Purpose  : Scoreboard bench for id_stage_pipelined: directed scenarios    |
// |            followed by randomized traffic against a behavioural model.     |
// |            Honours DECODE_WB_BYPASS_EN the same way as the design build.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_id_stage_pipelined;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 16;
  localparam int IMM_W   = 24;
  localparam int SHOP_W  = 12;
  localparam int RA_W    = 4;

  // ALU command per data-processing opcode, -1 = undefined encoding
  localparam int ALU_TAB [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [23:0] imm24;
    logic [11:0] shop;
    logic        imm;
    logic [3:0]  exe;
    logic        mem_r;
    logic        mem_w;
    logic        wb;
    logic        b;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  status = '0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  id_stage_pipelined_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .IMM_W(IMM_W), .SHOP_W(SHOP_W)) bus ();

  id_stage_pipelined #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .IMM_W(IMM_W), .SHOP_W(SHOP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .status  (status),
    .hazard  (hazard),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  logic m_valid = 1'b0;
  logic [31:0] rf [REG_CNT];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    bit tab [16];
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    tab = '{z, !z, cy, !cy, n, !n, v, !v, cy && !z, !cy || z,
            n == v, n != v, !z && (n == v), z || (n != v), 1'b1, 1'b0};
    return tab[c];
  endfunction

  function automatic logic [31:0] rf_read(input logic [3:0] a);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return rf[a];
  endfunction

  function automatic bit is_store(input logic [31:0] instr);
    return instr[27:26] == 2'd1 && !instr[20];
  endfunction

  function automatic bit two_src(input logic [31:0] instr);
    bit reads_rn;
    reads_rn = !(instr[27:26] == 2'd2) &&
               !(instr[27:26] == 2'd0 && (instr[24:21] == 4'd13 || instr[24:21] == 4'd15));
    return !instr[25] || is_store(instr) || reads_rn;
  endfunction

  function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] st);
    exp_t e;
    int   op;
    e       = '0;
    op      = int'(instr[24:21]);
    e.pc    = pc;
    e.dst   = instr[15:12];
    e.src1  = instr[19:16];
    e.src2  = is_store(instr) ? instr[15:12] : instr[3:0];
    e.rn    = rf_read(e.src1);
    e.rm    = rf_read(e.src2);
    e.imm24 = instr[23:0];
    e.shop  = instr[11:0];
    e.imm   = instr[25];
    if (cond_holds(instr[31:28], st)) begin
      if (instr[27:26] == 2'd0 && ALU_TAB[op] >= 0) begin
        e.exe = 4'(ALU_TAB[op]);
        e.wb  = !(op == 8 || op == 10);
        e.s   = instr[20];
      end else if (instr[27:26] == 2'd1) begin
        e.exe = 4'd2;
        if (instr[20]) begin e.mem_r = 1'b1; e.wb = 1'b1; end
        else           e.mem_w = 1'b1;
      end else if (instr[27:26] == 2'd2) begin
        e.b = 1'b1;
      end
    end
    return e;
  endfunction

  // Expected occupancy and register contents advance on the clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      sb_q.delete();
      for (int i = 0; i < REG_CNT; i++) rf[i] = '0;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
        sb_q.delete();
      end else if (bus.in_valid && !hazard && (!m_valid || bus.out_ready)) begin
        sb_q.push_back(predict(bus.in_pc, bus.in_instr, status));
        m_valid = 1'b1;
      end else if (!(m_valid && !bus.out_ready)) begin
        m_valid = 1'b0;
      end
      if (wb_en && int'(wb_addr) < REG_CNT) rf[wb_addr] = wb_data;
    end
  end

  // ------------------------------------------------------------------ monitor
  always @(negedge clk) begin
    exp_t act;
    chk("in_ready", 160'(bus.in_ready), 160'(!hazard && (!m_valid || bus.out_ready) && !flush));
    chk("hz_src1", 160'(bus.hz_src1), 160'(bus.in_instr[19:16]));
    chk("hz_src2", 160'(bus.hz_src2), 160'(is_store(bus.in_instr) ? bus.in_instr[15:12] : bus.in_instr[3:0]));
    chk("hz_two_src", 160'(bus.hz_two_src), 160'(two_src(bus.in_instr)));
    chk("out_valid", 160'(bus.out_valid), 160'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 160'(1), 160'(0));
      end else begin
        act = '{pc: bus.out_pc, rn: bus.out_rn, rm: bus.out_rm, dst: bus.out_dst,
                src1: bus.out_src1, src2: bus.out_src2, imm24: bus.out_imm24,
                shop: bus.out_shop, imm: bus.out_imm, exe: bus.out_exe_cmd,
                mem_r: bus.out_mem_r, mem_w: bus.out_mem_w, wb: bus.out_wb,
                b: bus.out_b, s: bus.out_s};
        chk("id_ex_bundle", 160'(act), 160'(sb_q[0]));
        if (bus.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // ----------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  task automatic rand_inputs();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom % 6)
      0, 1:    ins[27:26] = 2'd0;
      2:       ins[27:26] = 2'd1;
      3:       ins[27:26] = 2'd2;
      default: ;
    endcase
    if ($urandom % 10 < 6) ins[31:28] = 4'hE;
    bus.in_valid  = ($urandom % 10) < 8;
    bus.in_pc     = $urandom;
    bus.in_instr  = ins;
    bus.out_ready = ($urandom % 10) < 7;
    status        = 4'($urandom);
    hazard        = ($urandom % 10) < 2;
    flush         = ($urandom % 12) == 0;
    wb_en         = ($urandom % 2) == 0;
    wb_addr       = ($urandom % 3 == 0) ? ins[19:16] : 4'($urandom);
    wb_data       = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = 32'hE0821003;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 160'(bus.out_valid), 160'(0));
    chk("reset_out_rn", 160'(bus.out_rn), 160'(0));
    chk("reset_hz_src1", 160'(bus.hz_src1), 160'(2));
    step();

    // R2 = 7, R3 = 9
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd7; step();
    wb_addr = 4'd3; wb_data = 32'd9; step();
    wb_en = 1'b0;

    // ADD R1, R2, R3
    present(32'h100, 32'hE0821003);
    @(negedge clk);
    chk("add_hz_two_src", 160'(bus.hz_two_src), 160'(1));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 160'(bus.out_valid), 160'(1));
    chk("add_exe", 160'(bus.out_exe_cmd), 160'(4'b0010));
    chk("add_wb", 160'(bus.out_wb), 160'(1));
    chk("add_rn", 160'(bus.out_rn), 160'(7));
    chk("add_rm", 160'(bus.out_rm), 160'(9));
    chk("add_dst", 160'(bus.out_dst), 160'(1));
    step();

    // same ADD while R2 is written with 0x55 in the accept cycle
    present(32'h104, 32'hE0821003);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
    step();
    bus.in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
`ifdef DECODE_WB_BYPASS_EN
    chk("writethrough_rn", 160'(bus.out_rn), 160'(32'h55));
`else
    chk("writethrough_rn", 160'(bus.out_rn), 160'(7));
`endif
    step();

    // MOV R0, #5
    present(32'h108, 32'hE3A00005);
    @(negedge clk);
    chk("mov_hz_two_src", 160'(bus.hz_two_src), 160'(0));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mov_exe", 160'(bus.out_exe_cmd), 160'(4'b0001));
    chk("mov_imm", 160'(bus.out_imm), 160'(1));
    chk("mov_shop", 160'(bus.out_shop), 160'(12'h005));
    step();

    // STR R1, [R2, #4]
    present(32'h10C, 32'hE5821004);
    @(negedge clk);
    chk("str_hz_src2", 160'(bus.hz_src2), 160'(1));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("str_ctrl", 160'({bus.out_exe_cmd, bus.out_mem_w, bus.out_wb}), 160'({4'b0010, 1'b1, 1'b0}));
    step();

    // ADDEQ with Z=0 -> NOP in the slot
    status = 4'b0000;
    present(32'h110, 32'h00821003);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("condfail_valid", 160'(bus.out_valid), 160'(1));
    chk("condfail_ctrl", 160'({bus.out_exe_cmd, bus.out_mem_r, bus.out_mem_w, bus.out_wb, bus.out_b, bus.out_s}), 160'(0));
    step();

    // B +0x10
    present(32'h114, 32'hEA000010);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("branch_b", 160'(bus.out_b), 160'(1));
    chk("branch_imm24", 160'(bus.out_imm24), 160'(24'h000010));
    step();

    // backpressure, then a hazard bubble
    present(32'h200, 32'hE0821003);
    step();
    present(32'h204, 32'hE3A00005);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 160'(bus.in_ready), 160'(0));
      chk("bp_out_pc", 160'(bus.out_pc), 160'(32'h200));
      step();
    end
    bus.out_ready = 1'b1;
    hazard = 1'b1;
    step();
    @(negedge clk);
    chk("bubble_valid", 160'(bus.out_valid), 160'(0));
    step();
    hazard = 1'b0;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("retained_pc", 160'(bus.out_pc), 160'(32'h204));
    step();

    // flush while the register is stalled
    present(32'h300, 32'hE0821003);
    step();
    present(32'h304, 32'hE3A00005);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 160'(bus.in_ready), 160'(0));
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 160'(bus.out_valid), 160'(0));
    step();

    // randomized traffic with one reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if (i == 1500) begin
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_valid", 160'(bus.out_valid), 160'(0));
        chk("midreset_rn", 160'(bus.out_rn), 160'(0));
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    bus.in_valid = 1'b0;
    hazard = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised decode stage that merges decode, condition check, register file and the ID/EX pipeline register into one block.
- Uses a valid/ready handshake in place of a bare freeze input.
- Supports flush (taken branch) and hazard-inserted bubbles.
- Sits between the IF/ID register and the EX stage.
- Drives unregistered source-register info to the hazard unit.

Parameters:
DATA_W, 32, register/data width
REG_CNT, 16, number of architectural registers; RA_W = $clog2(REG_CNT)
IMM_W, 24, signed-immediate (branch offset) field width
SHOP_W, 12, shifter-operand field width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts in_instr this cycle
in_pc  in  DATA_W  PC of incoming instruction
in_instr  in  32  incoming instruction
status  in  4  NZCV flags from status register
hazard  in  1  hazard unit requests a bubble
flush  in  1  taken branch: kill in-flight/held instruction
wb_en  in  1  register-file write enable
wb_addr  in  RA_W  write address
wb_data  in  DATA_W  write data
hz_src1  out  RA_W  comb.: instr[19:16]
hz_src2  out  RA_W  comb.: instr[15:12] if store, else instr[3:0]
hz_two_src  out  1  comb.: (~I | store) OR has_src1 (non-MOV/MVN/B)
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc, out_rn, out_rm  out  DATA_W  registered PC, Rn value, Rm value
out_dst  out  RA_W  instr[15:12]
out_src1, out_src2  out  RA_W  registered source addresses
out_imm24  out  IMM_W  instr[23:0]
out_shop  out  SHOP_W  instr[11:0]
out_imm  out  1  instr[25]
out_exe_cmd  out  4  ALU command
out_mem_r, out_mem_w, out_wb, out_b, out_s  out  1  control flags

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; all out_* and registers cleared to 0.
  - Reset mid-operation discards the held instruction.
- Input handshake:
  - in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
  - Accept = in_valid & in_ready; the ID/EX register loads on the next rising edge. Latency is 1 cycle.
- Hold: out_valid & ~out_ready -> all out_* hold stable.
- Bubble: hazard=1 with downstream free -> out_valid<=0; the instruction is not consumed.
- Flush: flush=1 -> out_valid<=0 next edge; flush takes priority over accept and over hold.
- Decode (mode=instr[27:26], op=instr[24:21], S=instr[20]):
  - mode 00 op: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
  - mode 00 flags: wb=1 except CMP/TST; s=S.
  - mode 01 (LDR/STR, op 0100): exe_cmd=0010.
    - S=1: mem_r=1, wb=1.
    - S=0: mem_w=1.
  - mode 10: b=1.
  - Undefined encodings: all controls 0.
- Condition: standard ARM cond codes 0000..1110 evaluated on status at the accept cycle; 1111 = never.
  - Failing condition: the instruction is accepted with out_valid=1 and exe_cmd, mem_r, mem_w, wb, b, s all 0 (NOP).
  - Data fields pass through unchanged.
- Register file: REG_CNT x DATA_W, posedge write, two async read ports, all registers reset to 0.
  - wb_addr >= REG_CNT -> write ignored.
- Width: out_rn/out_rm are full DATA_W; immediates are carried raw, with no sign extension here.

Optional Feature:
DECODE_WB_BYPASS_EN
- Defined: when wb_en and wb_addr equals a read address in the same cycle, that read returns wb_data (write-through). The ID/EX register captures the new value.
- Undefined: reads return the pre-write value; the hazard unit must stall that case.

Decomposition:
- Package id_pkg: EX-command localparams, opcode/mode/cond localparams, NZCV bit indices, and a struct typedef for the ID/EX control bundle (exe_cmd, mem_r, mem_w, wb, b, s).
- One sub-module: id_regfile (register file plus the optional bypass).
- Decode and condition logic stay as combinational always blocks in the top.

Test Plan:
- Reset check: rst pulse mid-stream -> out_valid=0, out_rn=0, hazard outputs follow in_instr.
- ADD and write-through:
  - wb R2=7, R3=9 done; in_instr=0xE0821003 accepted -> next cycle out_valid=1, exe_cmd=0010, wb=1, out_rn=7, out_rm=9, out_dst=1, hz_two_src=1.
  - Same cycle wb_en R2=0x55: with bypass, out_rn=0x55; without, out_rn=7.
- MOV and STR decode:
  - 0xE3A00005 -> exe_cmd=0001, imm=1, shop=0x005, hz_two_src=0.
  - 0xE5821004 -> mem_w=1, wb=0, exe_cmd=0010, hz_src2=1.
- Failing condition and branch:
  - 0x00821003 with status Z=0 -> out_valid=1, all controls 0.
  - 0xEA000010 -> b=1, out_imm24=0x000010.
- Backpressure:
  - out_ready=0 for 3 cycles -> in_ready=0 and outputs stable.
  - Then hazard=1 with out_ready=1 -> one bubble (out_valid=0), instruction retained, accepted after hazard drops.
- Flush: flush=1 while out_valid=1 and out_ready=0 -> out_valid=0 next edge, in_ready=0 during the flush cycle.
